// File: rtl/bin_to_bcd_if.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_if
// Brief    : Request/result bundle for the binary-to-BCD converter.
// Revision : 1.0 - initial release
// ============================================================================
interface bin_to_bcd_if #(
    parameter int w_bin   = 16,
    parameter int w_digit = 5
);
    logic                   start;
    logic [w_bin-1:0]       bin;
    logic                   busy;
    logic                   done;
    logic [w_digit*4-1:0]   number;
    logic                   ovf;
    logic [w_digit-1:0]     blank;

    modport master (
        output start, bin,
        input  busy, done, number, ovf, blank
    );

    modport slave (
        input  start, bin,
        output busy, done, number, ovf, blank
    );
endinterface
`default_nettype wire

// File: rtl/bin_to_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_converter
// Brief    : Sequential double-dabble converter, one bit per clock.
//            Define BIN_TO_BCD_LEADING_ZERO_BLANK_EN for leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_converter #(
    parameter int w_bin   = 16,
    parameter int w_digit = 5
) (
    input  wire          clk,
    input  wire          rst,
    bin_to_bcd_if.slave  bus
);
    localparam int              c_acc_w = w_digit * 4;
    localparam int              c_cnt_w = $clog2(w_bin);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(w_bin - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    logic [w_bin-1:0]     r_sr;
    logic [c_acc_w-1:0]   r_acc;
    logic                 r_carry;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [c_acc_w-1:0]   r_number;
    logic                 r_ovf;

    logic [c_acc_w-1:0]   w_acc_adj;
    logic [c_acc_w-1:0]   w_acc_next;
    logic                 w_carry_next;

    // One double-dabble step: correct every digit >= 5, then shift left.
    always_comb begin
        w_acc_adj = '0;
        for (int d = 0; d < w_digit; d++) begin
            w_acc_adj[d*4 +: 4] = (r_acc[d*4 +: 4] >= 4'd5) ? r_acc[d*4 +: 4] + 4'd3
                                                             : r_acc[d*4 +: 4];
        end
        w_acc_next   = {w_acc_adj[c_acc_w-2:0], r_sr[w_bin-1]};
        w_carry_next = r_carry | w_acc_adj[c_acc_w-1];
    end

`ifdef BIN_TO_BCD_LEADING_ZERO_BLANK_EN
    logic [w_digit-1:0] r_blank;
    logic [w_digit-1:0] w_blank_next;
    logic               w_all_zero;

    // Scan from the top digit down; digit 0 always stays visible.
    always_comb begin
        w_blank_next = '0;
        w_all_zero   = 1'b1;
        for (int i = w_digit - 1; i >= 1; i--) begin
            w_all_zero      = w_all_zero && (w_acc_next[i*4 +: 4] == 4'd0);
            w_blank_next[i] = w_all_zero;
        end
    end

    assign bus.blank = r_blank;
`else
    assign bus.blank = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sr     <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_number <= '0;
            r_ovf    <= 1'b0;
`ifdef BIN_TO_BCD_LEADING_ZERO_BLANK_EN
            r_blank  <= '0;
`endif
        end else begin
            case (r_state)
                S_SHIFT: begin
                    r_sr    <= {r_sr[w_bin-2:0], 1'b0};
                    r_acc   <= w_acc_next;
                    r_carry <= w_carry_next;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_number <= w_acc_next;
                        r_ovf    <= w_carry_next;
`ifdef BIN_TO_BCD_LEADING_ZERO_BLANK_EN
                        r_blank  <= w_blank_next;
`endif
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request.
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= S_SHIFT;
                        r_busy  <= 1'b1;
                        r_sr    <= bus.bin;
                        r_acc   <= '0;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.number = r_number;
    assign bus.ovf    = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd_converter
// Brief    : Drives a 5-digit and a 4-digit converter with shared stimulus and
//            compares both against a decimal reference model every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_converter;
`ifdef BIN_TO_BCD_LEADING_ZERO_BLANK_EN
    localparam bit c_blank_on = 1'b1;
`else
    localparam bit c_blank_on = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] bin;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    bin_to_bcd_if #(.w_bin(16), .w_digit(5)) bus5 ();
    bin_to_bcd_if #(.w_bin(16), .w_digit(4)) bus4 ();

    assign bus5.start = start;
    assign bus5.bin   = bin;
    assign bus4.start = start;
    assign bus4.bin   = bin;

    bin_to_bcd_converter #(.w_bin(16), .w_digit(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5.slave));
    bin_to_bcd_converter #(.w_bin(16), .w_digit(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- decimal reference model ----------------
    function automatic longint unsigned pow10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [39:0] bcd_of(input longint unsigned v, input int nd);
        logic [39:0] r = '0;
        for (int i = 0; i < nd; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Digits i..nd-1 are all zero exactly when the kept value is below 10^i.
    function automatic logic [9:0] blank_of(input longint unsigned v, input int nd);
        logic [9:0] r = '0;
        longint unsigned m = v % pow10(nd);
        if (c_blank_on) begin
            for (int i = 1; i < nd; i++) r[i] = (m < pow10(i));
        end
        return r;
    endfunction

    int          busy_left = 0;
    logic [15:0] cap       = '0;
    logic        m_busy    = 1'b0;
    logic        m_done    = 1'b0;
    logic [19:0] m_num5    = '0;
    logic        m_ovf5    = 1'b0;
    logic [4:0]  m_blank5  = '0;
    logic [15:0] m_num4    = '0;
    logic        m_ovf4    = 1'b0;
    logic [3:0]  m_blank4  = '0;

    always @(posedge clk or posedge rst) begin
        logic [39:0] t;
        logic [9:0]  b;
        if (rst) begin
            busy_left = 0; cap = '0; m_busy = 1'b0; m_done = 1'b0;
            m_num5 = '0; m_ovf5 = 1'b0; m_blank5 = '0;
            m_num4 = '0; m_ovf4 = 1'b0; m_blank4 = '0;
        end else begin
            m_done = 1'b0;
            if (busy_left == 0) begin
                if (start) begin
                    cap       = bin;
                    busy_left = 16;
                end
            end else begin
                busy_left--;
                if (busy_left == 0) begin
                    m_done   = 1'b1;
                    t        = bcd_of(cap, 5);   m_num5 = t[19:0];
                    t        = bcd_of(cap, 4);   m_num4 = t[15:0];
                    m_ovf5   = (cap >= pow10(5));
                    m_ovf4   = (cap >= pow10(4));
                    b        = blank_of(cap, 5); m_blank5 = b[4:0];
                    b        = blank_of(cap, 4); m_blank4 = b[3:0];
                end
            end
            m_busy = (busy_left != 0);
        end
    end

    always @(negedge clk) begin
        check("busy5",   bus5.busy,   m_busy);
        check("done5",   bus5.done,   m_done);
        check("number5", bus5.number, m_num5);
        check("ovf5",    bus5.ovf,    m_ovf5);
        check("blank5",  bus5.blank,  m_blank5);
        check("busy4",   bus4.busy,   m_busy);
        check("done4",   bus4.done,   m_done);
        check("number4", bus4.number, m_num4);
        check("ovf4",    bus4.ovf,    m_ovf4);
        check("blank4",  bus4.blank,  m_blank4);
    end

    // ---------------- stimulus ----------------
    task automatic convert(input logic [15:0] v, input logic [19:0] e5, input logic [15:0] e4,
                           input logic eo4, input logic [4:0] eb5, input bit noise);
        int n = 0;
        @(negedge clk); start = 1'b1; bin = v;
        @(negedge clk); start = 1'b0; bin = 16'($urandom);
        while (!bus5.done && n < 40) begin
            @(negedge clk);
            n++;
            start = noise && (n == 5 || n == 9);
            if (start) bin = 16'($urandom);
        end
        start = 1'b0;
        check("done_seen", bus5.done, 1'b1);
        check("latency",   n, 16);
        check("lit_num5",  bus5.number, e5);
        check("lit_ovf5",  bus5.ovf, 1'b0);
        check("lit_num4",  bus4.number, e4);
        check("lit_ovf4",  bus4.ovf, eo4);
        check("lit_blank5", bus5.blank, c_blank_on ? eb5 : 5'b00000);
    endtask

    task automatic run_one(input logic [15:0] v);
        int n = 0;
        @(negedge clk); start = 1'b1; bin = v;
        @(negedge clk); start = 1'b0;
        while (!bus5.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rand_done", bus5.done, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int prev, dones;
        start = 1'b0; bin = '0; rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", bus5.busy, 1'b0);
        check("rst_done", bus5.done, 1'b0);
        check("rst_num",  bus5.number, 20'h0);
        check("rst_blank", bus5.blank, 5'b0);
        rst = 1'b0;

        convert(16'd12345, 20'h12345, 16'h2345, 1'b1, 5'b00000, 1'b0);
        convert(16'd0,     20'h00000, 16'h0000, 1'b0, 5'b11110, 1'b0);
        convert(16'd65535, 20'h65535, 16'h5535, 1'b1, 5'b00000, 1'b0);
        convert(16'd9999,  20'h09999, 16'h9999, 1'b0, 5'b10000, 1'b1);
        convert(16'd305,   20'h00305, 16'h0305, 1'b0, 5'b11000, 1'b1);
        convert(16'd10000, 20'h10000, 16'h0000, 1'b1, 5'b00000, 1'b0);
        repeat (3) @(negedge clk);
        check("hold_num5", bus5.number, 20'h10000);

        // Back-to-back with start held high
        @(negedge clk); start = 1'b1; bin = 16'd42;
        prev = 0; dones = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus5.done) begin
                if (dones == 0) begin
                    check("b2b_num42", bus5.number, 20'h00042);
                    bin = 16'd7;
                end else begin
                    check("b2b_gap", c - prev, 17);
                    check("b2b_num7", bus5.number, 20'h00007);
                end
                prev = c;
                dones++;
            end
        end
        start = 1'b0;
        check("b2b_count", dones, 3);
        repeat (20) @(negedge clk);

        // Reset in the middle of a conversion
        @(negedge clk); start = 1'b1; bin = 16'd999;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", bus5.busy, 1'b0);
        check("mid_rst_num",  bus5.number, 20'h0);
        check("mid_rst_ovf4", bus4.ovf, 1'b0);
        #2 rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("no_done_after_rst", bus5.done, 1'b0);
        end
        convert(16'd4096, 20'h04096, 16'h4096, 1'b0, 5'b10000, 1'b0);

        for (int k = 0; k < 1500; k++) run_one(16'($urandom));

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
